seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle 32-bit ALU.
- Single-cycle ops (add, sub, logic, shifts) complete in 1 cycle. MUL/DIV/MOD run on an iterative shift-add / restoring-divide datapath that takes WIDTH cycles.
- valid/ready handshake on both input and output, so the execute stage can stall on long ops.
- Drives the same flag set as the existing ALU: carry_out, overflow, negative, zero.

Parameters:
- WIDTH, 32, operand/result width; power of 2, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand / shift amount
- alu_control  input  6  opcode
- abort  input  1  synchronous cancel of in-flight op
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- alu_result  output  WIDTH  result
- carry_out  output  1  carry/borrow flag
- overflow  output  1  signed overflow / MUL high-half nonzero
- negative  output  1  alu_result[WIDTH-1]
- zero  output  1  alu_result == 0
- illegal_op  output  1  opcode not supported
- div_by_zero  output  1  DIV/MOD with operand_b == 0

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0 except in_ready=1. Any in-flight op is discarded.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating; counter runs 0..WIDTH-1.
  - DONE: out_valid=1; results held stable until out_ready.
- Accept: on a rising edge with in_valid&&in_ready, operands and opcode are latched.
- Single-cycle ops, IDLE->DONE, out_valid on the next cycle:
  - 000000 ADD
  - 000001 SUB
  - 010000 AND
  - 010001 OR
  - 010010 XOR
  - 100000 SLL
  - 100001 SRL
  - 100010 SRA
- Iterative ops, IDLE->BUSY for WIDTH cycles, then DONE; out_valid asserts WIDTH+1 cycles after accept:
  - 000010 MUL
  - 000011 DIV
  - 000100 MOD
- Any other opcode: single-cycle; alu_result=0, illegal_op=1, other flags 0.
- DONE -> IDLE when out_ready=1. in_ready=0 in DONE (no skid; one op in flight). Back-to-back single-cycle throughput is 1 op per 2 cycles.
- Arithmetic (all unsigned except flags):
  - ADD: carry_out = bit WIDTH of the (WIDTH+1)-bit sum; overflow = signed overflow.
  - SUB: carry_out = 1 when a<b (borrow); overflow = signed overflow.
  - MUL: result = low WIDTH bits of the product; overflow = (high half != 0); carry_out=0.
  - DIV/MOD: unsigned restoring division, one quotient bit per cycle, MSB first.
  - b==0: DIV result = all ones, MOD result = operand_a, div_by_zero=1. Still takes the full WIDTH+1 latency.
  - Shifts use operand_b[SHW-1:0]; upper bits ignored. SRA replicates operand_a[WIDTH-1]. Shift by 0 returns operand_a.
  - Logic and shift ops: carry_out=0, overflow=0.
- negative and zero are always derived from the registered alu_result.
- abort:
  - In BUSY: go to IDLE next cycle; no out_valid.
  - In DONE: drop the result, go to IDLE.
  - In IDLE: ignored. abort takes priority over in_valid on the same edge.
- Inputs changing while BUSY have no effect (operands are latched).

Optional Feature:
- Macro SEQ_ALU_MULH_EN.
- Defined: opcode 001000 = MULHU. Runs the same iterative multiply and returns the high WIDTH bits of the product; overflow=0, latency WIDTH+1.
- Undefined: 001000 is illegal (result 0, illegal_op=1), and the high-half product register may be pruned. Overflow semantics of MUL are unchanged either way.

Test Plan:
- WIDTH=32: ADD 0xFFFFFFFF+0x1 with out_ready=1 -> out_valid 1 cycle after accept; result 0, zero=1, carry_out=1, overflow=0.
- MUL 0x5*0x4 -> out_valid exactly 33 cycles after accept, result 0x14. Then 0x10000*0x10000 -> result 0, overflow=1.
- DIV 0x10/0x3 -> 0x5; MOD -> 0x1. DIV 0x10/0 -> 0xFFFFFFFF with div_by_zero=1; MOD 0x10/0 -> 0x10.
- Hold out_ready=0 for 5 cycles after SRA 0x80000000>>2 -> result 0xE0000000 and negative=1 held stable; in_ready=0 until out_ready=1.
- abort 10 cycles into a DIV -> no out_valid, in_ready=1 next cycle, next ADD 5+3 -> 0x8. rst_n low mid-MUL -> outputs 0 asynchronously.
- Opcode 001000 with 0xFFFFFFFF*0x2 -> with SEQ_ALU_MULH_EN: result 0x1. Without it: result 0, illegal_op=1. WIDTH=8 rerun: MUL latency 9 cycles, 0xF*0x11 -> 0xFF.

Source files
------------

// File: rtl/seq_alu_if.sv
// ============================================================================
// seq_alu_if : request/response bundle for the multi-cycle ALU.
// Rev 1.0
// ============================================================================
`default_nettype none

interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [5:0]       alu_control;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_result;
   logic             carry_out;
   logic             overflow;
   logic             negative;
   logic             zero;
   logic             illegal_op;
   logic             div_by_zero;

   modport master (
      output in_valid, operand_a, operand_b, alu_control, abort, out_ready,
      input  in_ready, out_valid, alu_result, carry_out, overflow,
             negative, zero, illegal_op, div_by_zero
   );

   modport slave (
      input  in_valid, operand_a, operand_b, alu_control, abort, out_ready,
      output in_ready, out_valid, alu_result, carry_out, overflow,
             negative, zero, illegal_op, div_by_zero
   );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : multi-cycle ALU, 1-cycle ALU ops plus iterative MUL/DIV/MOD.
// Optional MULHU opcode enabled by macro SEQ_ALU_MULH_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 32
) (
   input wire        clk,
   input wire        rst_n,
   seq_alu_if.slave  bus
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_MUL   = 6'b000010;
   localparam logic [5:0] OP_DIV   = 6'b000011;
   localparam logic [5:0] OP_MOD   = 6'b000100;
   localparam logic [5:0] OP_MULHU = 6'b001000;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_OR    = 6'b010001;
   localparam logic [5:0] OP_XOR   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b100000;
   localparam logic [5:0] OP_SRL   = 6'b100001;
   localparam logic [5:0] OP_SRA   = 6'b100010;

`ifdef SEQ_ALU_MULH_EN
   localparam logic MULH_EN = 1'b1;
`else
   localparam logic MULH_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [5:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             illegal_q, illegal_d;
   logic             dbz_q, dbz_d;

   logic             w_accept;
   logic             w_in_iter;
   logic             w_in_div;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [SHW-1:0]   w_sh;
   logic [WIDTH-1:0] w_sc_res;
   logic             w_sc_c;
   logic             w_sc_v;
   logic             w_sc_ill;

   assign w_accept  = (state_q == S_IDLE) && bus.in_valid && !bus.abort;
   assign w_in_div  = (bus.alu_control == OP_DIV) || (bus.alu_control == OP_MOD);
   assign w_in_iter = (bus.alu_control == OP_MUL) || w_in_div ||
                      (MULH_EN && (bus.alu_control == OP_MULHU));

   assign w_sum  = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
   assign w_diff = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
   assign w_sh   = bus.operand_b[SHW-1:0];

   // Single-cycle datapath, evaluated straight off the request so the result
   // can be registered on the accepting edge.
   always_comb begin
      w_sc_res = '0;
      w_sc_c   = 1'b0;
      w_sc_v   = 1'b0;
      w_sc_ill = 1'b0;
      case (bus.alu_control)
         OP_ADD: begin
            w_sc_res = w_sum[WIDTH-1:0];
            w_sc_c   = w_sum[WIDTH];
            w_sc_v   = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.operand_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_sc_res = w_diff[WIDTH-1:0];
            w_sc_c   = w_diff[WIDTH];
            w_sc_v   = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != bus.operand_a[WIDTH-1]);
         end
         OP_AND:  w_sc_res = bus.operand_a & bus.operand_b;
         OP_OR:   w_sc_res = bus.operand_a | bus.operand_b;
         OP_XOR:  w_sc_res = bus.operand_a ^ bus.operand_b;
         OP_SLL:  w_sc_res = bus.operand_a << w_sh;
         OP_SRL:  w_sc_res = bus.operand_a >> w_sh;
         OP_SRA:  w_sc_res = WIDTH'($signed(bus.operand_a) >>> w_sh);
         default: w_sc_ill = 1'b1;
      endcase
   end

   // One iteration step. Multiply: {hi,lo} starts as {0,b}, add a when the
   // current multiplier bit is set, shift right. Divide: {hi,lo} starts as
   // {0,a}; shift left, subtract b from the remainder when it fits.
   logic             w_op_div;
   logic [WIDTH:0]   w_madd;
   logic [WIDTH-1:0] w_mhi, w_mlo;
   logic [WIDTH:0]   w_rem_s;
   logic             w_ge;
   logic [WIDTH-1:0] w_dhi, w_dlo;
   logic [WIDTH-1:0] w_step_hi, w_step_lo;

   assign w_op_div  = (op_q == OP_DIV) || (op_q == OP_MOD);
   assign w_madd    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
   assign w_mhi     = w_madd[WIDTH:1];
   assign w_mlo     = {w_madd[0], lo_q[WIDTH-1:1]};
   assign w_rem_s   = {hi_q, lo_q[WIDTH-1]};
   assign w_ge      = (w_rem_s >= {1'b0, b_q});
   assign w_dhi     = w_ge ? (w_rem_s[WIDTH-1:0] - b_q) : w_rem_s[WIDTH-1:0];
   assign w_dlo     = {lo_q[WIDTH-2:0], w_ge};
   assign w_step_hi = w_op_div ? w_dhi : w_mhi;
   assign w_step_lo = w_op_div ? w_dlo : w_mlo;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      result_d  = result_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;
      dbz_d     = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               op_d  = bus.alu_control;
               a_d   = bus.operand_a;
               b_d   = bus.operand_b;
               cnt_d = '0;
               if (w_in_iter) begin
                  state_d = S_BUSY;
                  hi_d    = '0;
                  lo_d    = w_in_div ? bus.operand_a : bus.operand_b;
               end else begin
                  state_d   = S_DONE;
                  result_d  = w_sc_res;
                  carry_d   = w_sc_c;
                  ovf_d     = w_sc_v;
                  illegal_d = w_sc_ill;
                  dbz_d     = 1'b0;
               end
            end
         end
         S_BUSY: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               hi_d  = w_step_hi;
               lo_d  = w_step_lo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d   = S_DONE;
                  carry_d   = 1'b0;
                  illegal_d = 1'b0;
                  dbz_d     = w_op_div && (b_q == '0);
                  ovf_d     = (op_q == OP_MUL) && (w_step_hi != '0);
                  if ((op_q == OP_MOD) || (op_q == OP_MULHU))
                     result_d = w_step_hi;
                  else
                     result_d = w_step_lo;
               end
            end
         end
         S_DONE: begin
            if (bus.abort || bus.out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.out_valid   = (state_q == S_DONE);
   assign bus.alu_result  = result_q;
   assign bus.carry_out   = carry_q;
   assign bus.overflow    = ovf_q;
   assign bus.illegal_op  = illegal_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.negative    = result_q[WIDTH-1];
   // Gated by DONE so an all-zero reset value does not read as a zero result.
   assign bus.zero        = (state_q == S_DONE) && (result_q == '0);

endmodule

`default_nettype wire
